// File: rtl/display_scheduler_if.sv
// Request/ack and digit bus between the two display requesters and the scheduler.
// The master side drives the requests and watches the grants and digits.
interface display_scheduler_if;
    logic        req_a;
    logic [15:0] data_a;
    logic        req_b;
    logic [15:0] data_b;
    logic        ack_a;
    logic        ack_b;
    logic [1:0]  owner;
    logic [3:0]  first;
    logic [3:0]  second;
    logic [3:0]  third;
    logic [3:0]  fourth;

    modport master (
        output req_a, data_a, req_b, data_b,
        input  ack_a, ack_b, owner, first, second, third, fourth
    );

    modport slave (
        input  req_a, data_a, req_b, data_b,
        output ack_a, ack_b, owner, first, second, third, fourth
    );
endinterface

// File: rtl/display_scheduler.sv
// Round-robin arbiter sharing one 4-digit seven-segment display between two
// requesters, with a minimum ownership time enforced only against a competitor.
module display_scheduler #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic                clk,
    input  logic                rst_n,
    display_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rr_q, rr_d;
    logic               ack_a_q, ack_a_d;
    logic               ack_b_q, ack_b_d;
    logic [15:0]        digits_q, digits_d;
    logic               expired;

    assign expired = (cnt_q == HOLD_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_q     <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            digits_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            digits_q <= digits_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_a && bus.req_b) state_d = rr_q ? GRANT_B : GRANT_A;
                else if (bus.req_a)         state_d = GRANT_A;
                else if (bus.req_b)         state_d = GRANT_B;
            end
            GRANT_A: begin
                // Voluntary release skips the hold; preemption needs it expired.
                if (!bus.req_a)               state_d = bus.req_b ? GRANT_B : IDLE;
                else if (expired && bus.req_b) state_d = GRANT_B;
            end
            GRANT_B: begin
                if (!bus.req_b)               state_d = bus.req_a ? GRANT_A : IDLE;
                else if (expired && bus.req_a) state_d = GRANT_A;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_a_d  = (state_d == GRANT_A) && (state_q != GRANT_A);
        ack_b_d  = (state_d == GRANT_B) && (state_q != GRANT_B);
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;

        if (ack_a_d)      rr_d = 1'b1;
        else if (ack_b_d) rr_d = 1'b0;

        if (ack_a_d || ack_b_d || state_d == IDLE) cnt_d = '0;
        else if (!expired)                         cnt_d = cnt_q + CNT_W'(1);

        // Digits follow the next owner's word; IDLE leaves the last word shown.
        if (state_d == GRANT_A)      digits_d = bus.data_a;
        else if (state_d == GRANT_B) digits_d = bus.data_b;
    end

    assign bus.owner  = state_q;
    assign bus.ack_a  = ack_a_q;
    assign bus.ack_b  = ack_b_q;
    assign bus.first  = digits_q[15:12];
    assign bus.second = digits_q[11:8];
    assign bus.third  = digits_q[7:4];
    assign bus.fourth = digits_q[3:0];

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with HOLD_CYCLES=8: vector table plus
// hand sequences for preemption, long hold and asynchronous reset.
module tb_display_scheduler;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    display_scheduler_if bus ();

    display_scheduler #(
        .HOLD_CYCLES (8),
        .CNT_W       (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ra;
        logic [15:0] da;
        logic        rb;
        logic [15:0] db;
        logic [1:0]  own;
        logic        aa;
        logic        ab;
        logic [15:0] dig;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] own, input logic aa,
                              input logic ab, input logic [15:0] dig);
        check({tag, ".owner"}, 16'(bus.owner), 16'(own));
        check({tag, ".ack_a"}, 16'(bus.ack_a), 16'(aa));
        check({tag, ".ack_b"}, 16'(bus.ack_b), 16'(ab));
        check({tag, ".digits"}, {bus.first, bus.second, bus.third, bus.fourth}, dig);
    endtask

    task automatic drive(input logic ra, input logic [15:0] da, input logic rb, input logic [15:0] db);
        bus.req_a  = ra;
        bus.data_a = da;
        bus.req_b  = rb;
        bus.data_b = db;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset: assert mid-cycle, verify before any edge, release mid-cycle.
    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1 expect_out(tag, 2'b00, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("inv.both_acks", 16'(bus.ack_a && bus.ack_b), 16'h0000);
            check("inv.owner11", 16'(bus.owner == 2'b11), 16'h0000);
            check("inv.ack_idle", 16'(bus.owner == 2'b00 && (bus.ack_a || bus.ack_b)), 16'h0000);
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 16'h0000);

        vecs[0]  = '{1'b1, 16'h1234, 1'b0, 16'h0000, 2'b01, 1'b1, 1'b0, 16'h1234};
        vecs[1]  = '{1'b1, 16'h1234, 1'b0, 16'h0000, 2'b01, 1'b0, 1'b0, 16'h1234};
        vecs[2]  = '{1'b1, 16'hABCD, 1'b0, 16'h0000, 2'b01, 1'b0, 1'b0, 16'hABCD};
        vecs[3]  = '{1'b1, 16'hABCD, 1'b0, 16'h0000, 2'b01, 1'b0, 1'b0, 16'hABCD};
        vecs[4]  = '{1'b0, 16'hABCD, 1'b1, 16'h5678, 2'b10, 1'b0, 1'b1, 16'h5678};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h5678};
        vecs[6]  = '{1'b1, 16'h1111, 1'b0, 16'h0000, 2'b01, 1'b1, 1'b0, 16'h1111};
        vecs[7]  = '{1'b1, 16'h2222, 1'b0, 16'h0000, 2'b01, 1'b0, 1'b0, 16'h2222};
        vecs[8]  = '{1'b1, 16'h3333, 1'b0, 16'h0000, 2'b01, 1'b0, 1'b0, 16'h3333};
        vecs[9]  = '{1'b1, 16'h4444, 1'b0, 16'h0000, 2'b01, 1'b0, 1'b0, 16'h4444};
        vecs[10] = '{1'b0, 16'h9999, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h4444};
        vecs[11] = '{1'b1, 16'hAAAA, 1'b1, 16'hBBBB, 2'b10, 1'b0, 1'b1, 16'hBBBB};
        vecs[12] = '{1'b0, 16'hAAAA, 1'b0, 16'hBBBB, 2'b00, 1'b0, 1'b0, 16'hBBBB};
        vecs[13] = '{1'b1, 16'hAAAA, 1'b1, 16'hBBBB, 2'b01, 1'b1, 1'b0, 16'hAAAA};
        vecs[14] = '{1'b0, 16'hAAAA, 1'b0, 16'hBBBB, 2'b00, 1'b0, 1'b0, 16'hAAAA};
        vecs[15] = '{1'b0, 16'h7777, 1'b0, 16'h8888, 2'b00, 1'b0, 1'b0, 16'hAAAA};

        #12 expect_out("reset", 2'b00, 1'b0, 1'b0, 16'h0000);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].ra, vecs[i].da, vecs[i].rb, vecs[i].db);
            step();
            expect_out($sformatf("vec%0d", i), vecs[i].own, vecs[i].aa, vecs[i].ab, vecs[i].dig);
        end

        // Simultaneous requests after reset: A first, then alternate every 8 cycles.
        reset_pulse("rst1");
        drive(1'b1, 16'h1234, 1'b1, 16'h5678);
        step();
        expect_out("pre.grantA", 2'b01, 1'b1, 1'b0, 16'h1234);
        for (int i = 0; i < 7; i++) begin
            step();
            expect_out($sformatf("pre.holdA%0d", i), 2'b01, 1'b0, 1'b0, 16'h1234);
        end
        step();
        expect_out("pre.grantB", 2'b10, 1'b0, 1'b1, 16'h5678);
        for (int i = 0; i < 7; i++) begin
            step();
            expect_out($sformatf("pre.holdB%0d", i), 2'b10, 1'b0, 1'b0, 16'h5678);
        end
        step();
        expect_out("pre.regrantA", 2'b01, 1'b1, 1'b0, 16'h1234);

        // B alone keeps the display indefinitely.
        drive(1'b0, 16'h1234, 1'b1, 16'hBEEF);
        step();
        expect_out("long.grantB", 2'b10, 1'b0, 1'b1, 16'hBEEF);
        for (int i = 0; i < 100; i++) begin
            step();
            expect_out($sformatf("long.hold%0d", i), 2'b10, 1'b0, 1'b0, 16'hBEEF);
        end

        reset_pulse("rst2");
        drive(1'b1, 16'hC0DE, 1'b1, 16'hBEEF);
        step();
        expect_out("post_rst.tieA", 2'b01, 1'b1, 1'b0, 16'hC0DE);

        drive(1'b0, 16'h0000, 1'b0, 16'h0000);
        step();
        expect_out("post_rst.release", 2'b00, 1'b0, 1'b0, 16'hC0DE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
